// File: rtl/lcd_ahb_pkg.sv
// rtl/lcd_ahb_pkg.sv - register indices, FSM state type and defaults for the LCD AHB-Lite slave
package lcd_ahb_pkg;

  localparam int COORD_W_DEF = 16;

  localparam logic [3:0] IDX_RSTN     = 4'd4;
  localparam logic [3:0] IDX_EN       = 4'd5;
  localparam logic [3:0] IDX_INI_EN   = 4'd6;
  localparam logic [3:0] IDX_COLOR_EN = 4'd7;
  localparam logic [3:0] IDX_SC       = 4'd8;
  localparam logic [3:0] IDX_EC       = 4'd9;
  localparam logic [3:0] IDX_SP       = 4'd10;
  localparam logic [3:0] IDX_EP       = 4'd11;

  typedef enum logic [1:0] {IDLE, DATA, STALL} state_e;

  // Indices 8-11 are the window coordinates.
  function automatic logic is_coord(input logic [3:0] idx);
    return idx[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/lcd_win_bank.sv
// rtl/lcd_win_bank.sv - window coordinate registers, commit handshake and stall generation
module lcd_win_bank
  import lcd_ahb_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_dphase_i,
  input  logic               we_i,
  input  logic [3:0]         idx_i,
  input  logic [COORD_W-1:0] wdata_i,
  input  logic               win_ready_i,
  output logic [COORD_W-1:0] sc_o,
  output logic [COORD_W-1:0] ec_o,
  output logic [COORD_W-1:0] sp_o,
  output logic [COORD_W-1:0] ep_o,
  output logic               win_valid_o,
  output logic               stall_o
);

  logic [COORD_W-1:0] sc_q, ec_q, sp_q, ep_q;
  logic               win_valid_q, win_valid_d;

  // A new ep write re-arms the commit even on the edge the driver accepts the old one.
  always_comb begin
    win_valid_d = win_valid_q;
    if (win_valid_q && win_ready_i) win_valid_d = 1'b0;
    if (we_i && idx_i == IDX_EP)    win_valid_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sc_q        <= '0;
      ec_q        <= '0;
      sp_q        <= '0;
      ep_q        <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= win_valid_d;
      if (we_i) begin
        case (idx_i)
          IDX_SC:  sc_q <= wdata_i;
          IDX_EC:  ec_q <= wdata_i;
          IDX_SP:  sp_q <= wdata_i;
          IDX_EP:  ep_q <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign stall_o     = wr_dphase_i & is_coord(idx_i) & win_valid_q & ~win_ready_i;
  assign sc_o        = sc_q;
  assign ec_o        = ec_q;
  assign sp_o        = sp_q;
  assign ep_o        = ep_q;
  assign win_valid_o = win_valid_q;

endmodule

// File: rtl/ahblite_lcd_slave.sv
// rtl/ahblite_lcd_slave.sv - AHB-Lite LCD control/window register slave
// Define AHBLITE_LCD_READBACK_EN to build the register read-back mux.
module ahblite_lcd_slave
  import lcd_ahb_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HSIZE,
  input  logic [3:0]         HPROT,
  input  logic               HWRITE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  output logic               LCD_rstn,
  output logic               LCD_en,
  output logic               LCD_ini_en,
  output logic               LCD_color_en,
  output logic [COORD_W-1:0] LCD_set_sc,
  output logic [COORD_W-1:0] LCD_set_ec,
  output logic [COORD_W-1:0] LCD_set_sp,
  output logic [COORD_W-1:0] LCD_set_ep,
  output logic               win_valid,
  input  logic               win_ready
);

  state_e     state_q;
  logic [3:0] idx_q;
  logic       wr_q;
  logic       rstn_q, en_q, ini_en_q, color_en_q;
  logic       addr_ok, dphase, stall, we;

  assign addr_ok = HSEL & HTRANS[1] & HREADY;
  assign dphase  = (state_q != IDLE);
  assign we      = dphase & wr_q & ~stall;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      if (addr_ok) begin
        idx_q <= HADDR[5:2];
        wr_q  <= HWRITE;
      end
      case (state_q)
        IDLE:        state_q <= addr_ok ? DATA : IDLE;
        DATA, STALL: begin
          if (stall)       state_q <= STALL;
          else if (HREADY) state_q <= addr_ok ? DATA : IDLE;
          else             state_q <= DATA;
        end
        default:     state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rstn_q     <= 1'b0;
      en_q       <= 1'b0;
      ini_en_q   <= 1'b0;
      color_en_q <= 1'b0;
    end else if (we) begin
      case (idx_q)
        IDX_RSTN:     rstn_q     <= HWDATA[0];
        IDX_EN:       en_q       <= HWDATA[0];
        IDX_INI_EN:   ini_en_q   <= HWDATA[0];
        IDX_COLOR_EN: color_en_q <= HWDATA[0];
        default: ;
      endcase
    end
  end

  lcd_win_bank #(.COORD_W(COORD_W)) u_win_bank (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .wr_dphase_i (dphase & wr_q),
    .we_i        (we),
    .idx_i       (idx_q),
    .wdata_i     (HWDATA[COORD_W-1:0]),
    .win_ready_i (win_ready),
    .sc_o        (LCD_set_sc),
    .ec_o        (LCD_set_ec),
    .sp_o        (LCD_set_sp),
    .ep_o        (LCD_set_ep),
    .win_valid_o (win_valid),
    .stall_o     (stall)
  );

`ifdef AHBLITE_LCD_READBACK_EN
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (dphase && !wr_q) begin
      case (idx_q)
        IDX_RSTN:     rdata[0] = rstn_q;
        IDX_EN:       rdata[0] = en_q;
        IDX_INI_EN:   rdata[0] = ini_en_q;
        IDX_COLOR_EN: rdata[0] = color_en_q;
        IDX_SC:       rdata[COORD_W-1:0] = LCD_set_sc;
        IDX_EC:       rdata[COORD_W-1:0] = LCD_set_ec;
        IDX_SP:       rdata[COORD_W-1:0] = LCD_set_sp;
        IDX_EP: begin
          rdata[COORD_W-1:0] = LCD_set_ep;
          rdata[31]          = win_valid;
        end
        default: ;
      endcase
    end
  end
  assign HRDATA = rdata;
`else
  assign HRDATA = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA[31:COORD_W]};

  assign HREADYOUT    = ~stall;
  assign HRESP        = 1'b0;
  assign LCD_rstn     = rstn_q;
  assign LCD_en       = en_q;
  assign LCD_ini_en   = ini_en_q;
  assign LCD_color_en = color_en_q;

endmodule

// File: tb/tb_ahblite_lcd_slave.sv
// tb/tb_ahblite_lcd_slave.sv - self-checking bench for ahblite_lcd_slave
module tb_ahblite_lcd_slave;

`ifdef AHBLITE_LCD_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        HCLK, HRESETn, HSEL, HWRITE, hready, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        LCD_rstn, LCD_en, LCD_ini_en, LCD_color_en, win_valid, win_ready;
  logic [15:0] LCD_set_sc, LCD_set_ec, LCD_set_sp, LCD_set_ep;

  assign hready = HREADYOUT;

  ahblite_lcd_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .LCD_rstn(LCD_rstn), .LCD_en(LCD_en), .LCD_ini_en(LCD_ini_en), .LCD_color_en(LCD_color_en),
    .LCD_set_sc(LCD_set_sc), .LCD_set_ec(LCD_set_ec), .LCD_set_sp(LCD_set_sp), .LCD_set_ep(LCD_set_ep),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  off;
    bit          wr;
    logic [31:0] wdata;
    logic [7:0]  chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_out(input logic [7:0] off);
    case (off)
      8'h10:   return {31'b0, LCD_rstn};
      8'h14:   return {31'b0, LCD_en};
      8'h18:   return {31'b0, LCD_ini_en};
      8'h1C:   return {31'b0, LCD_color_en};
      8'h20:   return {16'b0, LCD_set_sc};
      8'h24:   return {16'b0, LCD_set_ec};
      8'h28:   return {16'b0, LCD_set_sp};
      8'h2C:   return {16'b0, LCD_set_ep};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Single non-pipelined transfer; returns read data and the number of wait states seen.
  task automatic xfer(input logic [7:0] off, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int waits);
    bit done;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + {24'b0, off}; HWRITE = wr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
    waits = 0; rdata = '0; done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        rdata = HRDATA;
        done  = 1'b1;
        break;
      end
      waits++;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL xfer_timeout: off 0x%02h still stalled after 32 cycles", off);
    end
    @(posedge HCLK); #1;
  endtask

  logic [31:0] rd, exp_v;
  int          waits, waits_a;

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'h0; HWRITE = 1'b0; HWDATA = '0; win_ready = 1'b0;

    vecs.push_back('{8'h10, 1'b1, 32'h0000_0001, 8'h10, 32'h1});
    vecs.push_back('{8'h10, 1'b0, 32'h0,         8'h00, RB ? 32'h1 : 32'h0});
    vecs.push_back('{8'h14, 1'b1, 32'hFFFF_FFFE, 8'h14, 32'h0});
    vecs.push_back('{8'h14, 1'b1, 32'h0000_0003, 8'h14, 32'h1});
    vecs.push_back('{8'h1C, 1'b1, 32'h0000_0001, 8'h1C, 32'h1});
    vecs.push_back('{8'h20, 1'b1, 32'h1234_ABCD, 8'h20, 32'h0000_ABCD});
    vecs.push_back('{8'h20, 1'b0, 32'h0,         8'h00, RB ? 32'h0000_ABCD : 32'h0});
    vecs.push_back('{8'h04, 1'b1, 32'h0000_FFFF, 8'h10, 32'h1});
    vecs.push_back('{8'h04, 1'b0, 32'h0,         8'h00, 32'h0});
    vecs.push_back('{8'h3C, 1'b1, 32'h0000_0055, 8'h2C, 32'h0});
    vecs.push_back('{8'h2C, 1'b1, 32'h0000_0005, 8'h2C, 32'h5});
    vecs.push_back('{8'h2C, 1'b0, 32'h0,         8'h00, RB ? 32'h5 : 32'h0});
    vecs.push_back('{8'h30, 1'b0, 32'h0,         8'h00, 32'h0});

    // Reset state
    #3;
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("rst_lcd_rstn",  {31'b0, LCD_rstn},  32'h0);
    check("rst_win_valid", {31'b0, win_valid}, 32'h0);
    check("rst_hrdata",    HRDATA,             32'h0);
    check("rst_hresp",     {31'b0, HRESP},     32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Table: driver always ready, so no transfer may stall
    win_ready = 1'b1;
    foreach (vecs[i]) begin
      sb_q.push_back(vecs[i].exp);
      xfer(vecs[i].off, vecs[i].wr, vecs[i].wdata, rd, waits);
      exp_v = sb_q.pop_front();
      if (vecs[i].wr) check($sformatf("vec%0d_out", i), get_out(vecs[i].chk), exp_v);
      else            check($sformatf("vec%0d_rdata", i), rd, exp_v);
      check($sformatf("vec%0d_waits", i), waits, 0);
    end

    // Window commit, then a coordinate write that stalls until the driver accepts
    win_ready = 1'b0;
    xfer(8'h20, 1'b1, 32'd0,   rd, waits);
    xfer(8'h24, 1'b1, 32'd239, rd, waits);
    xfer(8'h28, 1'b1, 32'd0,   rd, waits);
    xfer(8'h2C, 1'b1, 32'd319, rd, waits);
    check("win_sc", {16'b0, LCD_set_sc}, 32'd0);
    check("win_ec", {16'b0, LCD_set_ec}, 32'd239);
    check("win_sp", {16'b0, LCD_set_sp}, 32'd0);
    check("win_ep", {16'b0, LCD_set_ep}, 32'd319);
    check("win_valid_set", {31'b0, win_valid}, 32'h1);
    fork
      xfer(8'h20, 1'b1, 32'd10, rd, waits_a);
      begin
        @(posedge HCLK);
        @(negedge HCLK);
        check("stall_hreadyout", {31'b0, HREADYOUT}, 32'h0);
        check("stall_sc_held", {16'b0, LCD_set_sc}, 32'd0);
        repeat (3) @(posedge HCLK);
        #1 win_ready = 1'b1;
        @(posedge HCLK);
        #1 win_ready = 1'b0;
      end
    join
    check("stall_waits", waits_a, 3);
    check("stall_sc_after", {16'b0, LCD_set_sc}, 32'd10);
    check("stall_valid_cleared", {31'b0, win_valid}, 32'h0);

    // ep write landing on the accept edge keeps the commit pending
    xfer(8'h2C, 1'b1, 32'd100, rd, waits);
    check("ep_first_valid", {31'b0, win_valid}, 32'h1);
    fork
      xfer(8'h2C, 1'b1, 32'd200, rd, waits_a);
      begin
        @(posedge HCLK);
        #1 win_ready = 1'b1;
        @(posedge HCLK);
        #1 win_ready = 1'b0;
      end
    join
    check("ep_same_edge_waits", waits_a, 0);
    check("ep_same_edge_ep", {16'b0, LCD_set_ep}, 32'd200);
    check("ep_same_edge_valid", {31'b0, win_valid}, 32'h1);

    // Pipelined control writes and a read while the commit is pending
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + 32'h14; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = 32'h0; HADDR = BASE + 32'h18;
    @(negedge HCLK);
    check("b2b_hready_14", {31'b0, HREADYOUT}, 32'h1);
    @(posedge HCLK); #1;
    HWDATA = 32'h1; HADDR = BASE + 32'h1C; HWRITE = 1'b0;
    sb_q.push_back(RB ? 32'h1 : 32'h0);
    @(negedge HCLK);
    check("b2b_hready_18", {31'b0, HREADYOUT}, 32'h1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    check("b2b_hready_1c", {31'b0, HREADYOUT}, 32'h1);
    check("b2b_rdata_1c", HRDATA, sb_q.pop_front());
    @(posedge HCLK); #1;
    check("b2b_en", {31'b0, LCD_en}, 32'h0);
    check("b2b_ini_en", {31'b0, LCD_ini_en}, 32'h1);
    check("b2b_valid_pending", {31'b0, win_valid}, 32'h1);

    // Reset in the middle of a stalled coordinate write
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + 32'h24; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'd77;
    @(negedge HCLK);
    check("rst_stall_pre", {31'b0, HREADYOUT}, 32'h0);
    HRESETn = 1'b0;
    #1;
    check("rst_stall_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("rst_stall_regs",
          {20'b0, LCD_rstn, LCD_en, LCD_ini_en, LCD_color_en, LCD_set_sc ^ LCD_set_ec ^ LCD_set_sp ^ LCD_set_ep | {15'b0, win_valid}},
          32'h0);
    check("rst_stall_ep", {16'b0, LCD_set_ep}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check("rst_stall_ec_lost", {16'b0, LCD_set_ec}, 32'h0);
    check("rst_stall_valid", {31'b0, win_valid}, 32'h0);
    check("rst_stall_idle_ready", {31'b0, HREADYOUT}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
